// File: rtl/shift_register_rx.sv
// Serial-to-parallel receiver: oversamples an external serial clock/data pair, captures MSB-first
// on serial-clock rising edges and emits a WIDTH-bit word with a one-cycle valid strobe.
module shift_register_rx #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_serial_clk,
  input  logic             i_serial_data,
  output logic [WIDTH-1:0] o_parallel_data,
  output logic             o_data_valid,
  output logic             o_frame_error,
  output logic             o_busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

  localparam logic [CntW-1:0] CntFinal = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoOne   = TmoW'(1);

  typedef enum logic [0:0] {StIdle, StReceive} state_e;

  logic [SYNC_STAGES-1:0] sync_clk_q;
  logic [SYNC_STAGES-1:0] sync_data_q;
  logic                   prev_clk_q;
  logic                   sync_clk;
  logic                   sync_data;
  logic                   rise;

  state_e                 state_q, state_d;
  logic [WIDTH-2:0]       shift_q, shift_d;
  logic [WIDTH-1:0]       shift_next;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [TmoW-1:0]        tmo_inc;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;

  assign sync_clk   = sync_clk_q[SYNC_STAGES-1];
  assign sync_data  = sync_data_q[SYNC_STAGES-1];
  assign rise       = sync_clk & ~prev_clk_q;
  // Only WIDTH-1 bits are stored; the final bit joins them directly into the output word.
  assign shift_next = {shift_q, sync_data};
  assign tmo_inc    = tmo_q + TmoOne;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync_clk_q  <= '0;
      sync_data_q <= '0;
      prev_clk_q  <= 1'b0;
    end else begin
      sync_clk_q  <= {sync_clk_q[SYNC_STAGES-2:0], i_serial_clk};
      sync_data_q <= {sync_data_q[SYNC_STAGES-2:0], i_serial_data};
      prev_clk_q  <= sync_clk;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (rise) begin
      shift_d = shift_next[WIDTH-2:0];
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        tmo_d = '0;
        if (i_enable && rise) begin
          cnt_d   = CntOne;
          state_d = StReceive;
        end
      end
      StReceive: begin
        if (!i_enable) begin
          state_d = StIdle;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (rise) begin
          // A rise wins over a coinciding timeout expiry.
          tmo_d = '0;
          if (cnt_q == CntFinal) begin
            data_d  = shift_next;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else if (tmo_inc == TmoLast) begin
          ferr_d  = 1'b1;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_parallel_data = data_q;
  assign o_data_valid    = valid_q;
  assign o_frame_error   = ferr_q;
  assign o_busy          = (state_q == StReceive);

endmodule

// File: tb/tb_shift_register_rx.sv
// Self-checking bench for shift_register_rx: directed corner sequences, a vector table and a
// randomized frame stream compared against a frame-level model.
module tb_shift_register_rx;

  localparam int unsigned W    = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 1024;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         sclk;
  logic         sdata;
  logic [W-1:0] pdata;
  logic         valid;
  logic         ferr;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int valid_cnt   = 0;
  int ferr_cnt    = 0;
  int busy_cnt    = 0;
  int overlap_cnt = 0;
  int valid_cyc   = 0;
  int last_rise   = 0;
  logic [W-1:0] got_q[$];

  shift_register_rx #(
    .WIDTH         (W),
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_enable       (en),
    .i_serial_clk   (sclk),
    .i_serial_data  (sdata),
    .o_parallel_data(pdata),
    .o_data_valid   (valid),
    .o_frame_error  (ferr),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(pdata);
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (ferr)          ferr_cnt    = ferr_cnt + 1;
    if (busy)          busy_cnt    = busy_cnt + 1;
    if (valid && ferr) overlap_cnt = overlap_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit: data changes with the falling serial edge, sampled on the rising one.
  task automatic send_bit(input logic b, input int h);
    sclk  = 1'b0;
    sdata = b;
    repeat (h) tick();
    sclk      = 1'b1;
    last_rise = cyc;
    repeat (h) tick();
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int nb, input int h);
    for (int i = 0; i < nb; i++) send_bit(w[W-1-i], h);
  endtask

  typedef struct {
    logic [W-1:0] word;
    int           half;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, f0, b0, r0;
    int exp_err;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] word;

    rst_n = 1'b0;
    en    = 1'b0;
    sclk  = 1'b0;
    sdata = 1'b0;
    repeat (4) tick();
    check("reset_data", 32'(pdata), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (4) tick();

    // 1: single frame, latency and busy window
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    send_bits(8'hA5, 8, 4);
    r0 = last_rise;
    repeat (6) tick();
    check("t1_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t1_data", 32'(pdata), 32'hA5);
    check("t1_latency", 32'(valid_cyc - r0), 32'(SYNC + 1));
    check("t1_busy_cycles", 32'(busy_cnt - b0), 32'(7 * 2 * 4));
    check("t1_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 2: back-to-back frames
    v0 = valid_cnt; f0 = ferr_cnt;
    got_q.delete();
    send_bits(8'h3C, 8, 4);
    send_bits(8'hC3, 8, 4);
    repeat (6) tick();
    check("t2_valid_count", 32'(valid_cnt - v0), 32'd2);
    check("t2_first", 32'(got_q.size() > 0 ? got_q[0] : 8'hxx), 32'h3C);
    check("t2_second", 32'(got_q.size() > 1 ? got_q[1] : 8'hxx), 32'hC3);
    check("t2_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 3: timeout after 5 bits
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bits(8'hFF, 5, 4);
    sclk = 1'b0;
    repeat (TMO + 10) tick();
    check("t3_ferr_count", 32'(ferr_cnt - f0), 32'd1);
    check("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("t3_data_kept", 32'(pdata), 32'hC3);
    check("t3_busy_low", 32'(busy), 32'h0);
    send_bits(8'h81, 8, 4);
    repeat (6) tick();
    check("t3_next_valid", 32'(valid_cnt - v0), 32'd1);
    check("t3_next_data", 32'(pdata), 32'h81);

    // 4: enable dropped mid-frame
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bits(8'hFF, 3, 4);
    en = 1'b0;
    repeat (5) tick();
    check("t4_busy_after_abort", 32'(busy), 32'h0);
    en = 1'b1;
    repeat (3) tick();
    check("t4_abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    send_bits(8'h5A, 8, 4);
    repeat (6) tick();
    check("t4_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t4_data", 32'(pdata), 32'h5A);
    check("t4_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 5: reset mid-frame
    send_bits(8'h00, 6, 4);
    sclk = 1'b0;
    repeat (4) tick();
    v0 = valid_cnt; f0 = ferr_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_data_zero", 32'(pdata), 32'h0);
    check("t5_valid_zero", 32'(valid), 32'h0);
    check("t5_ferr_zero", 32'(ferr), 32'h0);
    check("t5_busy_zero", 32'(busy), 32'h0);
    repeat (4) tick();
    send_bits(8'h7E, 8, 4);
    repeat (6) tick();
    check("t5_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t5_data", 32'(pdata), 32'h7E);
    check("t5_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 6: serial clock already high when enabled
    en = 1'b0;
    sclk = 1'b1;
    repeat (8) tick();
    en = 1'b1;
    repeat (8) tick();
    check("t6_no_spurious_busy", 32'(busy), 32'h0);
    v0 = valid_cnt;
    send_bits(8'h11, 8, 4);
    repeat (6) tick();
    check("t6_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t6_data", 32'(pdata), 32'h11);

    // Vector table: word, half period, expected word
    vecs[0] = '{word: 8'h00, half: 3, exp_data: 8'h00};
    vecs[1] = '{word: 8'hFF, half: 3, exp_data: 8'hFF};
    vecs[2] = '{word: 8'h80, half: 5, exp_data: 8'h80};
    vecs[3] = '{word: 8'h01, half: 6, exp_data: 8'h01};
    vecs[4] = '{word: 8'h69, half: 4, exp_data: 8'h69};
    vecs[5] = '{word: 8'hB7, half: 7, exp_data: 8'hB7};
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt; f0 = ferr_cnt;
      send_bits(vecs[i].word, 8, vecs[i].half);
      repeat (6) tick();
      check($sformatf("vec%0d_count", i), 32'(valid_cnt - v0), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(pdata), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'd0);
    end

    // Random frame stream: model keeps the words of completed frames and counts stalled ones
    got_q.delete();
    f0 = ferr_cnt;
    exp_err = 0;
    for (int f = 0; f < 40; f++) begin
      int  h, nb;
      bit  stall;
      word  = W'($urandom);
      h     = int'($urandom_range(3, 6));
      stall = ($urandom_range(0, 6) == 0);
      nb    = stall ? int'($urandom_range(1, W - 1)) : W;
      for (int i = 0; i < nb; i++) begin
        send_bit(word[W-1-i], h);
        if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 40)) tick();
      end
      if (stall) begin
        sclk = 1'b0;
        repeat (TMO + 20) tick();
        exp_err = exp_err + 1;
      end else begin
        exp_q.push_back(word);
      end
      repeat ($urandom_range(0, 12)) tick();
    end
    repeat (8) tick();
    check("rand_ferr_count", 32'(ferr_cnt - f0), 32'(exp_err));
    check("rand_word_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rand_word%0d", i), 32'(i < got_q.size() ? got_q[i] : 8'hxx),
            32'(exp_q[i]));
    end

    check("valid_ferr_overlap", 32'(overlap_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
